// File: rtl/dht11_sched_pkg.sv
// dht11_sched_pkg: states, command/response codes and response formatting for the DHT11 request scheduler
package dht11_sched_pkg;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_SEND0, S_SEND1} state_t;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUM    = 8'h02;

    localparam logic [7:0] RSP_OK   = 8'h07;
    localparam logic [7:0] RSP_ERR  = 8'h1F;
    localparam logic [7:0] RSP_TEMP = 8'h09;
    localparam logic [7:0] RSP_HUM  = 8'h08;
    localparam logic [7:0] RSP_INV  = 8'hFF;

    function automatic logic cmd_known(input logic [7:0] code);
        return code <= CMD_HUM;
    endfunction

    // {byte0, byte1} of the answer; a failed read answers every known command with RSP_ERR
    function automatic logic [15:0] rsp_bytes(input logic [7:0] code, input logic err,
                                              input logic [7:0] temp, input logic [7:0] hum);
        if (!cmd_known(code)) return {RSP_INV, code};
        if (err) return {RSP_ERR, 8'h00};
        return code == CMD_TEMP ? {RSP_TEMP, temp} :
               code == CMD_HUM  ? {RSP_HUM, hum}   : {RSP_OK, 8'h00};
    endfunction

endpackage

// File: rtl/sched_cmd_fifo.sv
// sched_cmd_fifo: command queue; a push into a full queue is taken when a pop happens in the same cycle
module sched_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // storage needs no reset; only slots below count are ever read
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

endmodule

// File: rtl/dht11_request_scheduler.sv
// dht11_request_scheduler: queues host commands, rate-limits DHT11 reads via a cache, streams 2-byte answers to uart_tx (CHECKSUM_VERIFY_EN adds frame checksum checking)
module dht11_request_scheduler
    import dht11_sched_pkg::*;
#(
    parameter int MIN_GAP_CYCLES = 100_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_code,
    output logic       dht_enable,
    output logic       dht_rst,
    input  logic       dht_readout_done,
    input  logic       dht_error,
    input  logic [7:0] dht_hum_int,
    input  logic [7:0] dht_hum_float,
    input  logic [7:0] dht_temp_int,
    input  logic [7:0] dht_temp_float,
    input  logic [7:0] dht_check_sum,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy
);
    localparam int GW = $clog2(MIN_GAP_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t      state;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]  head, cur_code, rsp1;
    logic [7:0]  cache_temp_int, cache_temp_float, cache_hum_int, cache_hum_float;
    logic        cache_valid, full, empty, pop, push, allowed, go_read, tx_ack, rd_err, csum_bad;
    logic        unused_bits;

    sched_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (cmd_code),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // the head stays queued while it needs a fresh read that the gap does not yet allow
    assign allowed   = gap_cnt == GW'(MIN_GAP_CYCLES);
    assign pop       = state == S_IDLE && !empty && (!cmd_known(head) || cache_valid || allowed);
    assign go_read   = cmd_known(head) && (!cache_valid || allowed);
    assign cmd_ready = rst_n && (!full || pop);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = state != S_IDLE || !empty;
    assign tx_ack    = tx_done && !tx_start;

`ifdef CHECKSUM_VERIFY_EN
    assign csum_bad = dht_hum_int + dht_hum_float + dht_temp_int + dht_temp_float != dht_check_sum;
`else
    assign csum_bad = 1'b0;
`endif

    assign rd_err      = dht_error || tmo_cnt == TW'(TIMEOUT_CYCLES - 1) || (dht_readout_done && csum_bad);
    assign unused_bits = ^{cache_hum_float, cache_temp_float, dht_check_sum};

    // clocks since the last read start, saturating at the minimum gap
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) gap_cnt <= GW'(MIN_GAP_CYCLES);
        else if (dht_rst) gap_cnt <= '0;
        else if (!allowed) gap_cnt <= gap_cnt + GW'(1);

    // request sequencing: pick command, optionally read the sensor, send two bytes
    always_ff @(posedge clock or negedge rst_n)
        if (!rst_n) begin
            state            <= S_IDLE;
            dht_enable       <= 1'b0;
            dht_rst          <= 1'b0;
            tx_start         <= 1'b0;
            tx_data          <= '0;
            rsp1             <= '0;
            cur_code         <= '0;
            tmo_cnt          <= '0;
            cache_valid      <= 1'b0;
            cache_temp_int   <= '0;
            cache_temp_float <= '0;
            cache_hum_int    <= '0;
            cache_hum_float  <= '0;
        end else begin
            dht_rst  <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                S_IDLE:
                    if (pop) begin
                        cur_code <= head;
                        if (go_read) begin
                            state      <= S_START;
                            dht_enable <= 1'b1;
                            dht_rst    <= 1'b1;
                        end else begin
                            {tx_data, rsp1} <= rsp_bytes(head, 1'b0, cache_temp_int, cache_hum_int);
                            tx_start        <= 1'b1;
                            state           <= S_SEND0;
                        end
                    end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (rd_err) begin
                        cache_valid     <= 1'b0;
                        {tx_data, rsp1} <= rsp_bytes(cur_code, 1'b1, 8'h00, 8'h00);
                        tx_start        <= 1'b1;
                        state           <= S_SEND0;
                    end else if (dht_readout_done) begin
                        cache_valid      <= 1'b1;
                        cache_temp_int   <= dht_temp_int;
                        cache_temp_float <= dht_temp_float;
                        cache_hum_int    <= dht_hum_int;
                        cache_hum_float  <= dht_hum_float;
                        {tx_data, rsp1}  <= rsp_bytes(cur_code, 1'b0, dht_temp_int, dht_hum_int);
                        tx_start         <= 1'b1;
                        state            <= S_SEND0;
                    end
                end
                S_SEND0:
                    if (tx_ack) begin
                        tx_data  <= rsp1;
                        tx_start <= 1'b1;
                        state    <= S_SEND1;
                    end
                S_SEND1:
                    if (tx_ack) begin
                        dht_enable <= 1'b0;
                        state      <= S_IDLE;
                    end
                default: state <= S_IDLE;
            endcase
        end

endmodule

// File: tb/tb_dht11_request_scheduler.sv
// tb_dht11_request_scheduler: randomized scoreboard bench with sensor/UART models and a reference answer model
module tb_dht11_request_scheduler;
    localparam int MIN_GAP = 200;
    localparam int TMO     = 50;
    localparam int DEPTH   = 4;
`ifdef CHECKSUM_VERIFY_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic       clock = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, tx_done = 1'b0;
    logic       dht_readout_done = 1'b0, dht_error = 1'b0;
    logic [7:0] cmd_code = '0;
    logic [7:0] dht_hum_int = '0, dht_hum_float = '0, dht_temp_int = '0, dht_temp_float = '0, dht_check_sum = '0;
    logic       cmd_ready, dht_enable, dht_rst, tx_start, busy;
    logic [7:0] tx_data;

    dht11_request_scheduler #(.MIN_GAP_CYCLES(MIN_GAP), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .dht_enable(dht_enable), .dht_rst(dht_rst), .dht_readout_done(dht_readout_done), .dht_error(dht_error),
        .dht_hum_int(dht_hum_int), .dht_hum_float(dht_hum_float), .dht_temp_int(dht_temp_int),
        .dht_temp_float(dht_temp_float), .dht_check_sum(dht_check_sum),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         mode;
        logic [7:0] t;
        logic [7:0] h;
    } plan_t;

    plan_t      plan_q[$];
    logic [7:0] exp_q[$];
    int         chk = 0, pass = 0, cyc = 0, rd_count = 0, exp_reads = 0, last_rst = -100000, rst_epoch = 0;
    int         tx_delay_min = 1, tx_delay_max = 3;
    bit         m_cache_valid = 1'b0;
    logic [7:0] m_t, m_h, uart_b;
    int         uart_ep;
    plan_t      drv_p;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // reference model: a command needs a sensor read unless the cache is valid and the gap has not passed
    task automatic issue(input logic [7:0] code, input bit allowed, input int mode, input logic [7:0] t, input logic [7:0] h);
        plan_t p;
        bit    ok;
        if (code > 8'h02) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(code);
            return;
        end
        if (m_cache_valid && !allowed) ok = 1'b1;
        else begin
            p.mode = mode; p.t = t; p.h = h;
            plan_q.push_back(p);
            exp_reads++;
            ok = (mode == 0) || (mode == 3 && !CSUM_ON);
            m_cache_valid = ok;
            if (ok) begin m_t = t; m_h = h; end
        end
        if (!ok) begin exp_q.push_back(8'h1F); exp_q.push_back(8'h00); end
        else if (code == 8'h01) begin exp_q.push_back(8'h09); exp_q.push_back(m_t); end
        else if (code == 8'h02) begin exp_q.push_back(8'h08); exp_q.push_back(m_h); end
        else begin exp_q.push_back(8'h07); exp_q.push_back(8'h00); end
    endtask

    task automatic push(input logic [7:0] code, input bit allowed, input int mode, input logic [7:0] t, input logic [7:0] h);
        int n = 0;
        issue(code, allowed, mode, t, h);
        cmd_valid = 1'b1;
        cmd_code  = code;
        while (!cmd_ready && n < 3000) begin @(negedge clock); n++; end
        check("cmd_accept_in_time", n < 3000, 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((busy || exp_q.size() != 0) && n < 5000) begin @(negedge clock); n++; end
        check("drain_in_time", n < 5000, 1);
    endtask

    // UART model: compare each started byte against the scoreboard, then acknowledge
    initial forever begin
        @(negedge clock);
        tx_done = 1'b0;
        if (tx_start) begin
            uart_b  = tx_data;
            uart_ep = rst_epoch;
            if (exp_q.size() == 0) begin
                chk++;
                $display("FAIL tx_unexpected: byte %0h sent with nothing expected", uart_b);
            end else check("tx_byte", uart_b, exp_q.pop_front());
            repeat ($urandom_range(tx_delay_min, tx_delay_max)) @(negedge clock);
            if (uart_ep == rst_epoch) begin
                check("tx_data_hold", tx_data, uart_b);
                tx_done = 1'b1;
            end
        end
    end

    // DHT11 driver model: answer each read start with the next planned outcome
    initial forever begin
        @(negedge clock);
        if (dht_rst) begin
            rd_count++;
            check("read_gap", (cyc - last_rst) >= MIN_GAP, 1);
            check("enable_with_rst", dht_enable, 1);
            last_rst = cyc;
            if (plan_q.size() == 0) begin
                chk++;
                $display("FAIL unexpected_read: dht_rst at cycle %0d with no read required", cyc);
            end else begin
                drv_p = plan_q.pop_front();
                repeat ($urandom_range(3, 10)) @(negedge clock);
                if (drv_p.mode == 0 || drv_p.mode == 3) begin
                    dht_hum_int      = drv_p.h;
                    dht_temp_int     = drv_p.t;
                    dht_hum_float    = 8'($urandom);
                    dht_temp_float   = 8'($urandom);
                    dht_check_sum    = dht_hum_int + dht_hum_float + dht_temp_int + dht_temp_float + 8'(drv_p.mode == 3);
                    dht_readout_done = 1'b1;
                end else if (drv_p.mode == 1) dht_error = 1'b1;
                @(negedge clock);
                dht_readout_done = 1'b0;
                dht_error        = 1'b0;
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clock);
        check("reset_outputs", {dht_enable, dht_rst, tx_start, tx_data, busy, cmd_ready}, 0);
        rst_n = 1'b1;
        @(negedge clock);
        check("ready_after_reset", cmd_ready, 1);
        check("idle_after_reset", busy, 0);

        // first read, then cached answers inside the gap
        push(8'h01, 1'b1, 0, 8'h19, 8'h37);
        wait_idle();
        check("reads_first", rd_count, 1);
        push(8'h02, 1'b0, 0, 8'h00, 8'h00);
        wait_idle();
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 3)), 1'b0, 0, 8'h00, 8'h00);
        wait_idle();
        check("reads_cached", rd_count, 1);

        // timeout, then a request that must wait out the gap
        repeat (MIN_GAP + 20) @(negedge clock);
        push(8'h00, 1'b1, 2, 8'h00, 8'h00);
        push(8'h01, 1'b0, 0, 8'($urandom), 8'($urandom));
        wait_idle();
        check("reads_timeout", rd_count, 3);

        // driver error, then re-read
        repeat (MIN_GAP + 20) @(negedge clock);
        push(8'h01, 1'b1, 1, 8'($urandom), 8'($urandom));
        push(8'h02, 1'b0, 0, 8'($urandom), 8'($urandom));
        wait_idle();
        check("reads_error", rd_count, 5);

        push(8'h05, 1'b0, 0, 8'h00, 8'h00);
        wait_idle();
        check("reads_invalid", rd_count, 5);

        // fill the queue behind a slow UART
        tx_delay_min = 20; tx_delay_max = 30;
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom_range(3, 255)), 1'b0, 0, 8'h00, 8'h00);
        check("full_not_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        push(8'($urandom_range(3, 255)), 1'b0, 0, 8'h00, 8'h00);
        push(8'($urandom_range(3, 255)), 1'b0, 0, 8'h00, 8'h00);
        tx_delay_min = 1; tx_delay_max = 3;
        wait_idle();

        // corrupted frame checksum
        repeat (MIN_GAP + 20) @(negedge clock);
        push(8'h01, 1'b1, 3, 8'($urandom), 8'($urandom));
        wait_idle();
        check("reads_checksum", rd_count, 6);

        // reset while the first byte is on the wire
        tx_delay_min = 15; tx_delay_max = 20;
        push(8'h05, 1'b0, 0, 8'h00, 8'h00);
        n = 0;
        while (!tx_start && n < 500) begin @(negedge clock); n++; end
        check("tx_start_before_reset", tx_start, 1);
        @(negedge clock);
        rst_n = 1'b0;
        rst_epoch++;
        #1;
        check("reset_mid_send", {dht_enable, dht_rst, tx_start, tx_data, busy, cmd_ready}, 0);
        exp_q.delete();
        m_cache_valid = 1'b0;
        last_rst = -100000;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        check("ready_after_mid_reset", cmd_ready, 1);
        check("idle_after_mid_reset", busy, 0);
        tx_delay_min = 1; tx_delay_max = 3;
        repeat (30) @(negedge clock);
        push(8'h02, 1'b1, 0, 8'($urandom), 8'($urandom));
        wait_idle();

        check("reads_total", rd_count, exp_reads);
        check("plans_consumed", plan_q.size(), 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
